seg7_scan: RTL

Eight-digit multiplexed seven-segment display driver for the board's two 4-digit banks. It sits downstream of the CPU's memory/IO stage and consumes 16-bit halfword writes that the IO decoder issues for the display address. It holds a 32-bit display value and scans both banks in parallel, one digit slot at a time. It also provides optional leading-zero blanking and per-digit blinking.

---
 rtl/seg7_pkg.sv | 38 +++
 rtl/seg7_scan_hex7seg.sv | 11 +
 rtl/seg7_scan.sv | 130 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the eight-digit seven-segment scanner.
package seg7_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned HALF_W     = 16;
  localparam int unsigned NUM_DIGITS = 8;

  // Segment bit positions within {g,f,e,d,c,b,a}
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  typedef logic [NIB_W-1:0] nibble_t;
  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  // Element n holds the pattern for hex value n (listed F down to 0).
  localparam logic [15:0][SEG_W-1:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic              hi;
    logic [HALF_W-1:0] data;
  } disp_wr_t;

  function automatic seg_t hex_to_seg(input nibble_t n);
    return HEX_SEG_TABLE[n];
  endfunction

endpackage

// File: rtl/seg7_scan_hex7seg.sv
// Combinational hex digit to seven-segment pattern decoder.
module hex7seg
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] i_hex,
  output logic [SEG_W-1:0] o_seg_c
);

  assign o_seg_c = hex_to_seg(i_hex);

endmodule

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment driver: two 4-digit banks scanned in
// parallel, with leading-zero blanking and per-digit blinking.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 25000,
  parameter int unsigned BLINK_SLOTS = 2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_hi,
  input  logic [HALF_W-1:0] wr_data,
  input  logic              blank_lz,
  input  logic [7:0]        blink_mask,
  output logic [7:0]        an,
  output logic [SEG_W-1:0]  seg_lo,
  output logic [SEG_W-1:0]  seg_hi
);

  localparam int unsigned PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BCNT_W = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

  logic [2*HALF_W-1:0] r_disp;
  logic [PRE_W-1:0]    r_pre;
  logic [1:0]          r_k;
  logic [BCNT_W-1:0]   r_bcnt;
  logic                r_bph;
  logic [7:0]          r_an;
  logic [SEG_W-1:0]    r_seg_lo;
  logic [SEG_W-1:0]    r_seg_hi;

  disp_wr_t                      w_wr;
  logic                          w_tick;
  logic                          w_bwrap;
  logic [1:0]                    w_k_next;
  logic [2:0]                    w_sel_lo;
  logic [2:0]                    w_sel_hi;
  logic [3:0]                    w_onehot;
  logic [NUM_DIGITS-1:0][NIB_W-1:0] w_digits;
  logic [NUM_DIGITS-1:0]         w_blank;
  logic                          w_above_nz;
  logic [SEG_W-1:0]              w_seg_lo_dec;
  logic [SEG_W-1:0]              w_seg_hi_dec;
  logic [7:0]                    w_an_nxt;
  logic [SEG_W-1:0]              w_seg_lo_nxt;
  logic [SEG_W-1:0]              w_seg_hi_nxt;

  assign w_wr     = '{hi: wr_hi, data: wr_data};
  assign w_tick   = (r_pre == PRE_W'(SCAN_DIV - 1));
  assign w_bwrap  = (r_bcnt == BCNT_W'(BLINK_SLOTS - 1));
  assign w_k_next = r_k + 2'd1;
  assign w_sel_lo = {1'b0, w_k_next};
  assign w_sel_hi = {1'b1, w_k_next};
  assign w_onehot = 4'b0001 << w_k_next;
  assign w_digits = r_disp;

  // Blank mask: a digit is dark when it and everything above it is zero, or when blinking off.
  always_comb begin
    w_above_nz = 1'b0;
    w_blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_above_nz = w_above_nz | (w_digits[3'(i)] != '0);
      w_blank[3'(i)] = (blank_lz && (i != 0) && !w_above_nz) ||
                       (blink_mask[3'(i)] && r_bph);
    end
  end

  hex7seg u_dec_lo (
    .i_hex   (w_digits[w_sel_lo]),
    .o_seg_c (w_seg_lo_dec)
  );

  hex7seg u_dec_hi (
    .i_hex   (w_digits[w_sel_hi]),
    .o_seg_c (w_seg_hi_dec)
  );

  // Output values for the slot that begins at the next boundary.
  always_comb begin
    w_an_nxt     = '0;
    w_seg_lo_nxt = SEG_BLANK;
    w_seg_hi_nxt = SEG_BLANK;
    if (!w_blank[w_sel_lo]) begin
      w_an_nxt[3:0] = w_onehot;
      w_seg_lo_nxt  = w_seg_lo_dec;
    end
    if (!w_blank[w_sel_hi]) begin
      w_an_nxt[7:4] = w_onehot;
      w_seg_hi_nxt  = w_seg_hi_dec;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_disp <= '0;
    end else if (wr_en) begin
      if (w_wr.hi) r_disp[31:16] <= w_wr.data;
      else         r_disp[15:0]  <= w_wr.data;
    end
  end

  // Prescaler, slot index, blink timing and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre    <= '0;
      r_k      <= '0;
      r_bcnt   <= '0;
      r_bph    <= 1'b0;
      r_an     <= '0;
      r_seg_lo <= SEG_BLANK;
      r_seg_hi <= SEG_BLANK;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
      if (w_tick) begin
        r_k      <= w_k_next;
        r_an     <= w_an_nxt;
        r_seg_lo <= w_seg_lo_nxt;
        r_seg_hi <= w_seg_hi_nxt;
        r_bcnt   <= w_bwrap ? '0 : r_bcnt + BCNT_W'(1);
        if (w_bwrap) r_bph <= ~r_bph;
      end
    end
  end

  assign an     = r_an;
  assign seg_lo = r_seg_lo;
  assign seg_hi = r_seg_hi;

endmodule
